gcn_dot_accumulator: RTL and testbench
======================================

# gcn_dot_accumulator

Downstream stage of the vector multiplier in the feature × weight transformation datapath. It consumes one product vector per handshake, reduces it to a dot product, and stores the result in an internal result matrix of FEATURE_ROWS × WEIGHT_COLS entries. It sequences the matrix with row/column counters and signals completion when every entry is written. The aggregation stage reads the results through a random-access port.

## Interface
- FEATURE_WIDTH, 8: width of each product element.
- WEIGHT_ROWS, 6: elements per product vector; equals the feature-column count.
- FEATURE_ROWS, 6: result-matrix rows.
- WEIGHT_COLS, 3: result-matrix columns.
- DOT_WIDTH, FEATURE_WIDTH+$clog2(WEIGHT_ROWS) = 11: result-entry width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a pass.
- prod_valid  in  1  product vector is valid.
- prod_ready  out  1  block accepts a product vector.
- prod_in  in  [FEATURE_WIDTH-1:0] × [0:WEIGHT_ROWS-1]  product vector from the vector multiplier.
- rd_row  in  $clog2(FEATURE_ROWS)  result read row.
- rd_col  in  $clog2(WEIGHT_COLS)  result read column.
- rd_data  out  DOT_WIDTH  combinational read of entry [rd_row][rd_col].
- busy  out  1  high in ACCUM and DRAIN.
- done  out  1  high in DONE.

## Operation
- Reset values: state IDLE, prod_ready 0, busy 0, done 0, all counters 0, sum register 0, valid flag 0, every result entry 0.
- All arithmetic is unsigned. The sum of WEIGHT_ROWS elements is zero-extended to DOT_WIDTH and cannot overflow.
- A transfer occurs on any clock edge where prod_valid and prod_ready are both high.
- Input order: all FEATURE_ROWS rows of column 0 arrive first (row 0 first), then column 1, and so on.
- FSM states:
  - IDLE: prod_ready=0. On start, clear all result entries and counters, then go to ACCUM.
  - ACCUM: prod_ready=1. On each transfer:
    - register the sum and its (row, col) index; set the valid flag.
    - increment row; on wrap from FEATURE_ROWS-1 to 0, increment col.
    - on the transfer of (FEATURE_ROWS-1, WEIGHT_COLS-1), go to DRAIN.
  - DRAIN: prod_ready=0. The pending entry is written, then go to DONE.
  - DONE: done=1, results are held. On start, behave as IDLE+start: clear results and go to ACCUM.
- The stage-2 write happens on every edge after the valid flag is set, independent of state.
- A start pulse in ACCUM or DRAIN is ignored.
- prod_valid outside ACCUM is ignored; no transfer occurs.
- An rd_row or rd_col index outside its range returns 0.
- Reset asserted mid-pass aborts the pass: return to IDLE, clear all results, and drop any pending write.

## Timing
- Two-stage pipeline: the transfer edge T registers the sum; edge T+1 writes the entry to the result matrix.
- rd_data shows the new value after edge T+1.
- Back-to-back transfers run at one per cycle with no bubbles.
- A pass takes FEATURE_ROWS×WEIGHT_COLS transfers plus one DRAIN cycle.
  - Defaults: 18 transfers. After the last transfer at edge T, done rises after edge T+1.
- start at edge S: prod_ready is high from edge S onward; results read 0 after edge S.

## Structure
- Shared package gcn_pkg holds the default widths and dimensions, the state enum (IDLE, ACCUM, DRAIN, DONE), and a function computing DOT_WIDTH.
- Sub-module: gcn_adder_tree, a combinational reduction of WEIGHT_ROWS elements to DOT_WIDTH bits.
- The top level contains the FSM, the counters, the pipeline register, and the result array.

## Test plan
- Reset, then 5 idle cycles → prod_ready=0, done=0, busy=0; every entry reads 0.
- Single-vector sum: start, then product vector {0,11,24,39,56,75} as row 0, col 0 → [0][0]=205 after one cycle.
- Full pass: start, then 18 back-to-back vectors with every element = row+col+1 → each entry = 6×(row+col+1); done exactly 1 cycle after the last transfer.
- Maximum value: all elements 255 → entry 1530; no overflow.
- Backpressure and invalid start:
  - prod_valid toggled every other cycle → only handshaken vectors are counted; order is preserved.
  - start pulse during ACCUM → ignored.
- Reset after 7 transfers → all entries 0, state IDLE. A new pass then completes correctly.

Source files
------------

// File: rtl/gcn_pkg.sv
// gcn_pkg: shared dimensions, state encoding and result-width helper for the GCN datapath
package gcn_pkg;
  localparam int DEF_FEATURE_WIDTH = 8;
  localparam int DEF_WEIGHT_ROWS = 6;
  localparam int DEF_FEATURE_ROWS = 6;
  localparam int DEF_WEIGHT_COLS = 3;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;
  function automatic int dot_width(input int fw, input int n);
    return fw + $clog2(n);
  endfunction
  localparam int DEF_DOT_WIDTH = dot_width(DEF_FEATURE_WIDTH, DEF_WEIGHT_ROWS);
endpackage

// File: rtl/gcn_adder_tree.sv
// gcn_adder_tree: combinational unsigned reduction of N elements into an OW-bit sum
module gcn_adder_tree import gcn_pkg::*; #(
  parameter int N = DEF_WEIGHT_ROWS,
  parameter int W = DEF_FEATURE_WIDTH,
  parameter int OW = dot_width(W, N)
) (
  input  logic [W-1:0]  elem_i [N],
  output logic [OW-1:0] sum_o
);
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N; i++) sum_o = sum_o + OW'(elem_i[i]);
  end
endmodule

// File: rtl/gcn_dot_accumulator.sv
// gcn_dot_accumulator: reduces product vectors to dot products and fills a
// FEATURE_ROWS x WEIGHT_COLS result matrix, column-major, with a random-access read port.
module gcn_dot_accumulator import gcn_pkg::*; #(
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int WEIGHT_ROWS = DEF_WEIGHT_ROWS,
  parameter int FEATURE_ROWS = DEF_FEATURE_ROWS,
  parameter int WEIGHT_COLS = DEF_WEIGHT_COLS,
  parameter int DOT_WIDTH = dot_width(FEATURE_WIDTH, WEIGHT_ROWS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            prod_valid,
  output logic                            prod_ready,
  input  logic [FEATURE_WIDTH-1:0]        prod_in [0:WEIGHT_ROWS-1],
  input  logic [$clog2(FEATURE_ROWS)-1:0] rd_row,
  input  logic [$clog2(WEIGHT_COLS)-1:0]  rd_col,
  output logic [DOT_WIDTH-1:0]            rd_data,
  output logic                            busy,
  output logic                            done
);
  localparam int RW = $clog2(FEATURE_ROWS);
  localparam int CW = $clog2(WEIGHT_COLS);
  state_e state_q, state_d;
  logic [RW-1:0] row_q, wr_row_q;
  logic [CW-1:0] col_q, wr_col_q;
  logic [DOT_WIDTH-1:0] sum, sum_q;
  logic [DOT_WIDTH-1:0] res_q [FEATURE_ROWS][WEIGHT_COLS];
  logic vld_q, xfer, clr, row_last, col_last;
  gcn_adder_tree #(.N(WEIGHT_ROWS), .W(FEATURE_WIDTH), .OW(DOT_WIDTH)) u_tree (
    .elem_i(prod_in),
    .sum_o (sum)
  );
  assign prod_ready = state_q == ACCUM;
  assign busy = state_q inside {ACCUM, DRAIN};
  assign done = state_q == DONE;
  assign xfer = prod_ready && prod_valid;
  assign clr = start && state_q inside {IDLE, DONE};
  assign row_last = row_q == RW'(FEATURE_ROWS - 1);
  assign col_last = col_q == CW'(WEIGHT_COLS - 1);
  assign rd_data = (32'(rd_row) < FEATURE_ROWS && 32'(rd_col) < WEIGHT_COLS) ? res_q[rd_row][rd_col] : '0;
  always_comb begin
    state_d = state_q;
    state_d = clr ? ACCUM :
              (xfer && row_last && col_last) ? DRAIN :
              state_q == DRAIN ? DONE : state_q;
  end
  // Stage 1 captures the sum and its index; stage 2 commits it on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      sum_q    <= '0;
      vld_q    <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++)
        for (int c = 0; c < WEIGHT_COLS; c++) res_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= xfer;
      if (xfer) begin
        sum_q    <= sum;
        wr_row_q <= row_q;
        wr_col_q <= col_q;
        row_q    <= row_last ? '0 : row_q + 1'b1;
        col_q    <= !row_last ? col_q : col_last ? '0 : col_q + 1'b1;
      end
      if (clr) begin
        row_q <= '0;
        col_q <= '0;
        for (int r = 0; r < FEATURE_ROWS; r++)
          for (int c = 0; c < WEIGHT_COLS; c++) res_q[r][c] <= '0;
      end else if (vld_q) begin
        res_q[wr_row_q][wr_col_q] <= sum_q;
      end
    end
  end
endmodule

// File: tb/tb_gcn_dot_accumulator.sv
// tb_gcn_dot_accumulator: directed stimulus checked every cycle against a matrix-level model
module tb_gcn_dot_accumulator;
  localparam int FR = 6;
  localparam int WC = 3;
  localparam int WR = 6;
  logic clk = 0, reset = 0, start = 0, prod_valid = 0;
  logic prod_ready, busy, done;
  logic [7:0] prod_in [0:WR-1];
  logic [2:0] rd_row = '0;
  logic [1:0] rd_col = '0;
  logic [10:0] rd_data;
  int n_err = 0, n_chk = 0;
  int m_mat [FR][WC];
  bit m_acc, m_drain, m_done, m_pend;
  int m_k, m_pr, m_pc, m_pv;
  bit chk_en = 0, sel_en = 0;
  int sel_r, sel_c, sweep = 0;
  logic [7:0] vec [WR];

  gcn_dot_accumulator dut (
    .clk(clk), .reset(reset), .start(start), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .prod_in(prod_in), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_read(input int r, input int c);
    return (r < FR && c < WC) ? m_mat[r][c] : 0;
  endfunction

  // Model: the k-th accepted vector of a pass lands at row k%FR, col k/FR one edge later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < FR; r++) for (int c = 0; c < WC; c++) m_mat[r][c] = 0;
      m_acc = 0; m_drain = 0; m_done = 0; m_pend = 0; m_k = 0;
    end else begin
      if (m_pend) begin
        m_mat[m_pr][m_pc] = m_pv;
        m_pend = 0;
      end
      if (m_drain) begin
        m_drain = 0;
        m_done = 1;
      end else if (m_acc && prod_valid) begin
        m_pv = 0;
        for (int i = 0; i < WR; i++) m_pv += int'(prod_in[i]);
        m_pr = m_k % FR;
        m_pc = m_k / FR;
        m_pend = 1;
        m_k++;
        if (m_k == FR * WC) begin
          m_acc = 0;
          m_drain = 1;
        end
      end else if (start && !m_acc) begin
        for (int r = 0; r < FR; r++) for (int c = 0; c < WC; c++) m_mat[r][c] = 0;
        m_k = 0; m_acc = 1; m_done = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sel_en) begin
        rd_row = 3'(sel_r);
        rd_col = 2'(sel_c);
      end else begin
        rd_row = 3'(sweep % 8);
        rd_col = 2'((sweep / 8) % 4);
        sweep++;
      end
      #1;
      if (chk_en && !reset) begin
        check("prod_ready", prod_ready, m_acc);
        check("busy", busy, m_acc || m_drain);
        check("done", done, m_done);
        check("rd_data", rd_data, m_read(rd_row, rd_col));
      end
    end
  end

  task automatic drive(input bit v);
    @(negedge clk);
    start = 0;
    prod_valid = v;
    for (int i = 0; i < WR; i++) prod_in[i] = vec[i];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      prod_valid = 0;
      start = 0;
    end
  endtask

  task automatic pulse_start;
    @(negedge clk);
    prod_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic read_chk(input int r, input int c, input int exp, input string name);
    sel_r = r;
    sel_c = c;
    sel_en = 1;
    @(negedge clk);
    prod_valid = 0;
    #2;
    check(name, rd_data, exp);
    sel_en = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      prod_valid = 0;
      #2;
      n++;
    end
    check(name, done, 1);
  endtask

  initial begin
    for (int i = 0; i < WR; i++) begin
      prod_in[i] = '0;
      vec[i] = '0;
    end
    #2 reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;
    idle(5);
    #2;
    check("rst_ready", prod_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    read_chk(0, 0, 0, "rst_e00");
    read_chk(5, 2, 0, "rst_e52");
    // single vector, then a start during ACCUM, then max-value vectors under backpressure
    pulse_start;
    vec = '{8'd0, 8'd11, 8'd24, 8'd39, 8'd56, 8'd75};
    drive(1);
    idle(1);
    read_chk(0, 0, 205, "single_e00");
    pulse_start;
    #2;
    check("ign_start_busy", busy, 1);
    check("ign_start_ready", prod_ready, 1);
    for (int i = 0; i < WR; i++) vec[i] = 8'd255;
    for (int k = 1; k < FR * WC; k++) begin
      drive(1);
      drive(0);
    end
    wait_done("bp_done");
    read_chk(0, 0, 205, "bp_e00");
    read_chk(1, 0, 1530, "max_e10");
    read_chk(5, 2, 1530, "max_e52");
    read_chk(7, 0, 0, "oor_row");
    read_chk(0, 3, 0, "oor_col");
    // full back-to-back pass restarted from DONE
    pulse_start;
    #2;
    check("start_ready", prod_ready, 1);
    read_chk(5, 2, 0, "start_clr_e52");
    for (int k = 0; k < FR * WC; k++) begin
      for (int i = 0; i < WR; i++) vec[i] = 8'(k % FR + k / FR + 1);
      drive(1);
    end
    @(negedge clk);
    prod_valid = 0;
    #2;
    check("done_early", done, 0);
    @(negedge clk);
    #2;
    check("done_t1", done, 1);
    read_chk(0, 0, 6, "full_e00");
    read_chk(2, 1, 24, "full_e21");
    read_chk(3, 0, 24, "full_e30");
    read_chk(5, 2, 48, "full_e52");
    // reset in the middle of a pass
    pulse_start;
    for (int i = 0; i < WR; i++) vec[i] = 8'd9;
    repeat (7) drive(1);
    @(negedge clk);
    prod_valid = 0;
    reset = 1;
    #2;
    check("mid_busy", busy, 0);
    check("mid_ready", prod_ready, 0);
    check("mid_done", done, 0);
    @(negedge clk);
    reset = 0;
    read_chk(0, 0, 0, "mid_e00");
    read_chk(0, 1, 0, "mid_e01");
    pulse_start;
    for (int k = 0; k < FR * WC; k++) begin
      for (int i = 0; i < WR; i++) vec[i] = 8'(k + i);
      drive(1);
    end
    wait_done("pass2_done");
    read_chk(0, 0, 15, "pass2_e00");
    read_chk(3, 2, 105, "pass2_e32");
    read_chk(5, 1, 81, "pass2_e51");
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
